// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side FIFO controller feeding a 2-entry in-order valid/ready output buffer
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  underflow_seen
);
    logic [1:0] occ, occ_next, wr_idx;
    logic inflight, pop;
    logic [FIFO_WIDTH-1:0] head, tail, head_next, tail_next;

    assign pop = m_valid & m_ready;
    assign m_valid = occ != 2'd0;
    assign m_data = head;
    assign idle = (occ == 2'd0) & !inflight;
    // m_ready reaches fifo_rd_en combinationally so a pop frees its slot in the same cycle
    assign fifo_rd_en = !rst & enable & !fifo_empty &
        (({1'b0, occ} + {2'b0, inflight}) < ({2'b0, pop} + 3'd2));

    // slot the captured word lands in, counted after this cycle's pop
    assign wr_idx = occ - {1'b0, pop};
    assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};
    assign head_next = (inflight && wr_idx == 2'd0) ? fifo_data_out : pop ? tail : head;
    assign tail_next = (inflight && wr_idx == 2'd1) ? fifo_data_out : tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ            <= 2'd0;
            inflight       <= 1'b0;
            head           <= '0;
            tail           <= '0;
            word_count     <= '0;
            underflow_seen <= 1'b0;
        end else begin
            occ            <= occ_next;
            inflight       <= fifo_rd_en;
            head           <= head_next;
            tail           <= tail_next;
            word_count     <= word_count + CNT_WIDTH'(pop);
            underflow_seen <= underflow_seen | fifo_underflow;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (occ <= 2'd2);
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and random stimulus against a FIFO model and in-order read scoreboard
module tb_fifo_stream_reader;
    localparam int W = 16;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1, fifo_underflow = 1'b0, m_ready = 1'b0;
    logic [W-1:0] fifo_data_out = '0;
    logic fifo_rd_en, m_valid, idle, underflow_seen;
    logic [W-1:0] m_data;
    logic [15:0] word_count;
    logic [W-1:0] q[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] wval = 16'd1, hold_data = '0, nxt, s_data;
    logic hold = 1'b0, armed = 1'b0, s_rd, s_valid, s_idle, found;
    int vecs = 0, errs = 0, cnt = 0, rds = 0, pops = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .idle(idle), .word_count(word_count),
        .underflow_seen(underflow_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, sample before the edge, advance the FIFO model after it
    task automatic step(input logic r, input logic rdy, input logic en, input int nw);
        logic p;
        rst = r;
        m_ready = rdy;
        enable = en;
        repeat (nw) begin
            q.push_back(wval);
            wval++;
        end
        fifo_empty = (q.size() == 0);
        #1;
        s_rd = fifo_rd_en;
        s_valid = m_valid;
        s_data = m_data;
        s_idle = idle;
        p = m_valid & m_ready & !r;
        if (r) chk("rd_in_reset", fifo_rd_en, 0);
        if (armed && !r) begin
            chk("count", word_count, cnt);
            chk("underflow", underflow_seen, 0);
            chk("idle", idle, sb.size() == 0);
            chk("room", sb.size() <= 2, 1);
            if (hold) chk("stable", {m_valid, m_data}, {1'b1, hold_data});
            if (p) chk("order", m_data, sb.size() != 0 ? {16'h0, sb[0]} : 32'hdead_beef);
        end
        if (fifo_rd_en) rds++;
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            cnt = 0;
            hold = 1'b0;
        end else begin
            if (p) begin
                void'(sb.pop_front());
                cnt = (cnt + 1) & 16'hffff;
                pops++;
            end
            hold = s_valid & !rdy;
            hold_data = s_data;
        end
        fifo_underflow = s_rd & (q.size() == 0);
        if (s_rd && q.size() != 0) begin
            fifo_data_out = q.pop_front();
            sb.push_back(fifo_data_out);
        end
        fifo_empty = (q.size() == 0);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 1'b1, 3);
        step(1'b1, 1'b0, 1'b1, 0);
        armed = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_idle", s_idle, 1);
        chk("rst_count", word_count, 0);
        q.delete();
        fifo_empty = 1'b1;
        wval = 16'd1;

        rds = 0;
        step(1'b0, 1'b1, 1'b1, 8);
        chk("lat0_valid", s_valid, 0);
        chk("lat0_rd", s_rd, 1);
        step(1'b0, 1'b1, 1'b1, 0);
        chk("lat1_valid", s_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 0);
            chk("stream_valid", s_valid, 1);
            chk("stream_data", s_data, i + 1);
        end
        step(1'b0, 1'b1, 1'b1, 0);
        chk("stream_end", s_valid, 0);
        chk("stream_cnt", word_count, 8);
        chk("stream_reads", rds, 8);
        chk("stream_fifo_empty", q.size(), 0);

        step(1'b1, 1'b0, 1'b0, 0);
        wval = 16'd1;
        rds = 0;
        pops = 0;
        step(1'b0, 1'b0, 1'b1, 8);
        repeat (9) step(1'b0, 1'b0, 1'b1, 0);
        chk("bp_reads", rds, 2);
        chk("bp_valid", s_valid, 1);
        chk("bp_head", s_data, 1);
        repeat (12) step(1'b0, 1'b1, 1'b1, 0);
        chk("bp_pops", pops, 8);
        chk("bp_drained", sb.size() + q.size(), 0);

        step(1'b0, 1'b1, 1'b0, 3);
        rds = 0;
        pops = 0;
        step(1'b0, 1'b1, 1'b1, 0);
        chk("en_rd", s_rd, 1);
        repeat (5) step(1'b0, 1'b1, 1'b0, 0);
        chk("en_reads", rds, 1);
        chk("en_pops", pops, 1);
        chk("en_idle", idle, 1);
        chk("en_left", q.size(), 2);
        pops = 0;
        repeat (8) step(1'b0, 1'b1, 1'b1, 0);
        chk("en_resume", pops, 2);

        repeat (400) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 9) < 4));
        for (int i = 0; i < 300 && (q.size() + sb.size()) != 0; i++) step(1'b0, 1'b1, 1'b1, 0);
        chk("rand_drained", sb.size() + q.size(), 0);
        chk("rand_idle", idle, 1);

        step(1'b0, 1'b1, 1'b1, 10);
        repeat (4) step(1'b0, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 0);
        nxt = q[0];
        step(1'b0, 1'b0, 1'b0, 0);
        chk("mid_valid", s_valid, 0);
        chk("mid_idle", s_idle, 1);
        chk("mid_count", word_count, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 0);
            if (s_valid) begin
                found = 1'b1;
                chk("mid_next_word", s_data, nxt);
            end
        end
        chk("mid_resumed", found, 1);
        for (int i = 0; i < 30 && (q.size() + sb.size()) != 0; i++) step(1'b0, 1'b1, 1'b1, 0);
        chk("mid_drained", sb.size() + q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
